// File: rtl/midi_rx_port.sv
// MIDI IN port: 2-FF line synchroniser, 8N1 byte decoder with framing
// error detection, and a stretched activity indicator.
module midi_rx_port #(
   parameter int CLKS_PER_BIT = 512,
   parameter int ACT_CYCLES   = 1600000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       midi_rx,
   output logic       midi_sync,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr,
   output logic       rx_busy,
   output logic       act_led
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(ACT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_CYCLES);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bidx;
   logic [7:0]    shreg;
   logic          meta;
   logic [AW-1:0] act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= 1'b1;
         midi_sync <= 1'b1;
      end else begin
         meta      <= midi_rx;
         midi_sync <= meta;
      end
   end

   // In WAIT_IDLE the bit counter doubles as the run length of high samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_IDLE;
         cnt      <= '0;
         bidx     <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         unique case (state)
            WAIT_IDLE: begin
               if (!midi_sync) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (!midi_sync) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  if (midi_sync) begin
                     state <= IDLE;
                  end else begin
                     bidx  <= '0;
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shreg <= {midi_sync, shreg[7:1]};
                  if (bidx == 3'd7) begin
                     bidx  <= '0;
                     state <= STOP;
                  end else begin
                     bidx <= bidx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (midi_sync) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     rx_ferr <= 1'b1;
                     state   <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= WAIT_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act <= '0;
      end else if (rx_valid) begin
         act <= ACT_LOAD;
      end else if (act != '0) begin
         act <= act - 1'b1;
      end
   end

   assign rx_busy = (state == START) || (state == DATA) || (state == STOP);
   assign act_led = (act != '0);

endmodule

// File: tb/tb_midi_rx_port.sv
// Randomised and directed bench for midi_rx_port, checked every cycle
// against a sample-point model of the MIDI line.
module tb_midi_rx_port;

   localparam int CPB = 16;
   localparam int ACT = 100;
   localparam int H   = CPB / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       midi_rx = 1'b1;
   logic       midi_sync;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic       rx_busy;
   logic       act_led;

   midi_rx_port #(
      .CLKS_PER_BIT(CPB),
      .ACT_CYCLES  (ACT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .midi_rx  (midi_rx),
      .midi_sync(midi_sync),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr),
      .rx_busy  (rx_busy),
      .act_led  (act_led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // model state: 0 waiting for idle run, 1 idle, 2 inside a frame
   int         mode = 0;
   int         run = 0;
   int         k0 = 0;
   int         lv = 0;
   bit         have_lv = 0;
   logic [7:0] mbyte = '0;
   logic [7:0] e_data = '0;
   logic       e_valid = 0;
   logic       e_ferr = 0;
   logic       e_led = 0;
   logic       e_busy = 0;
   logic       sq0 = 1;
   logic       sq1 = 1;

   int         vq[$];
   logic [7:0] dq[$];
   int         fq[$];
   int         act_hi = 0;
   int         rise = 0;
   int         last_act = 0;
   logic       prev_act = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   function automatic int qv(input int i);
      if (i < vq.size()) return vq[i];
      return -1;
   endfunction

   function automatic int qd(input int i);
      if (i < dq.size()) return int'(dq[i]);
      return -1;
   endfunction

   function automatic int qf(input int i);
      if (i < fq.size()) return fq[i];
      return -1;
   endfunction

   always @(posedge clk) begin : mdl
      logic v;
      int   rel;
      cyc++;
      if (!rst_n) begin
         mode = 0; run = 0; e_data = '0; e_valid = 0; e_ferr = 0;
         e_led = 0; e_busy = 0; have_lv = 0; sq0 = 1; sq1 = 1;
      end else begin
         v = sq1;
         e_valid = 0;
         e_ferr = 0;
         case (mode)
            0: begin
               if (v) begin
                  run++;
                  if (run == CPB) mode = 1;
               end else begin
                  run = 0;
               end
            end
            1: begin
               if (!v) begin
                  mode = 2;
                  k0 = cyc;
               end
            end
            default: begin
               rel = cyc - k0;
               if (rel == H) begin
                  if (v) mode = 1;
               end else if (rel > H && rel < H + 9 * CPB && (rel - H) % CPB == 0) begin
                  mbyte[(rel - H) / CPB - 1] = v;
               end else if (rel == H + 9 * CPB) begin
                  if (v) begin
                     e_valid = 1;
                     e_data = mbyte;
                     mode = 1;
                  end else begin
                     e_ferr = 1;
                     mode = 0;
                     run = 0;
                  end
               end
            end
         endcase
         e_led = have_lv && (cyc - lv) >= 1 && (cyc - lv) <= ACT;
         if (e_valid) begin
            have_lv = 1;
            lv = cyc;
         end
         e_busy = (mode == 2);
         sq1 = sq0;
         sq0 = midi_rx;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("midi_sync", 32'(midi_sync), 32'(sq1));
         chk("rx_valid", 32'(rx_valid), 32'(e_valid));
         chk("rx_ferr", 32'(rx_ferr), 32'(e_ferr));
         chk("rx_data", 32'(rx_data), 32'(e_data));
         chk("rx_busy", 32'(rx_busy), 32'(e_busy));
         chk("act_led", 32'(act_led), 32'(e_led));
      end
      if (rx_valid) begin
         vq.push_back(cyc);
         dq.push_back(rx_data);
      end
      if (rx_ferr) fq.push_back(cyc);
      if (act_led) begin
         act_hi++;
         last_act = cyc;
         if (!prev_act) rise++;
      end
      prev_act = act_led;
   end

   task automatic idle(input int n);
      midi_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input logic stopb, output int p);
      p = cyc + 1;
      midi_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         midi_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      midi_rx = stopb;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_sync"}, 32'(midi_sync), 32'd1);
      chk({tag, "_data"}, 32'(rx_data), 32'd0);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_ferr"}, 32'(rx_ferr), 32'd0);
      chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
      chk({tag, "_act"}, 32'(act_led), 32'd0);
   endtask

   initial begin
      int p, q, b, bf, ah, rs;
      logic [7:0] rb;
      logic sb;

      repeat (3) @(negedge clk);
      reset_vals("rst0");
      #3 rst_n = 1'b1;
      @(negedge clk);
      idle(30);

      b = vq.size(); ah = act_hi;
      frame(8'h90, 1'b1, p);
      idle(120);
      chk("single_n", 32'(vq.size() - b), 32'd1);
      chk("single_t", 32'(qv(b)), 32'(p + H + 2 + 9 * CPB));
      chk("single_d", 32'(qd(b)), 32'h90);
      chk("single_ferr", 32'(fq.size()), 32'd0);
      chk("single_act", 32'(act_hi - ah), 32'd100);

      b = vq.size();
      frame(8'h90, 1'b1, p);
      frame(8'h3C, 1'b1, q);
      frame(8'h7F, 1'b1, q);
      idle(40);
      chk("b2b_n", 32'(vq.size() - b), 32'd3);
      chk("b2b_t0", 32'(qv(b)), 32'(p + 154));
      chk("b2b_gap1", 32'(qv(b + 1) - qv(b)), 32'd160);
      chk("b2b_gap2", 32'(qv(b + 2) - qv(b + 1)), 32'd160);
      chk("b2b_d0", 32'(qd(b)), 32'h90);
      chk("b2b_d1", 32'(qd(b + 1)), 32'h3C);
      chk("b2b_d2", 32'(qd(b + 2)), 32'h7F);

      b = vq.size(); bf = fq.size();
      midi_rx = 1'b0;
      repeat (5) @(negedge clk);
      idle(30);
      chk("glitch_n", 32'(vq.size() - b), 32'd0);
      chk("glitch_ferr", 32'(fq.size() - bf), 32'd0);
      chk("glitch_busy", 32'(rx_busy), 32'd0);
      frame(8'hF8, 1'b1, p);
      idle(20);
      chk("glitch_next_n", 32'(vq.size() - b), 32'd1);
      chk("glitch_next_d", 32'(qd(b)), 32'hF8);

      b = vq.size(); bf = fq.size();
      frame(8'hA5, 1'b0, p);
      midi_rx = 1'b0;
      repeat (40) @(negedge clk);
      idle(8);
      frame(8'h00, 1'b1, q);
      idle(30);
      chk("ferr_n", 32'(fq.size() - bf), 32'd1);
      chk("ferr_t", 32'(qf(bf)), 32'(p + 154));
      chk("ferr_nodec", 32'(vq.size() - b), 32'd0);
      chk("ferr_keep", 32'(rx_data), 32'hF8);
      frame(8'h3C, 1'b1, q);
      idle(20);
      chk("ferr_next_n", 32'(vq.size() - b), 32'd1);
      chk("ferr_next_d", 32'(qd(b)), 32'h3C);

      b = vq.size(); bf = fq.size();
      midi_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      midi_rx = 1'b1; repeat (CPB) @(negedge clk);
      midi_rx = 1'b0; repeat (CPB) @(negedge clk);
      midi_rx = 1'b1; repeat (CPB) @(negedge clk);
      midi_rx = 1'b0; repeat (H) @(negedge clk);
      #3 rst_n = 1'b0;
      @(negedge clk);
      reset_vals("rstmid");
      repeat (5) @(negedge clk);
      #3 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      idle(30);
      chk("rstmid_none", 32'(vq.size() - b + fq.size() - bf), 32'd0);
      frame(8'h55, 1'b1, p);
      idle(20);
      chk("rstmid_n", 32'(vq.size() - b), 32'd1);
      chk("rstmid_d", 32'(qd(b)), 32'h55);

      idle(120);
      b = vq.size(); ah = act_hi; rs = rise;
      frame(8'h11, 1'b1, p);
      idle(60);
      frame(8'h22, 1'b1, q);
      idle(150);
      chk("act_n", 32'(vq.size() - b), 32'd2);
      chk("act_hi", 32'(act_hi - ah), 32'd200);
      chk("act_rise", 32'(rise - rs), 32'd2);
      chk("act_end", 32'(last_act), 32'(qv(b + 1) + ACT));

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            midi_rx = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            idle(20);
         end else begin
            rb = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 7) != 0);
            frame(rb, sb, p);
            idle($urandom_range(0, 30));
         end
      end
      idle(150);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
